// File: rtl/gray_pkg.sv
// Shared constants and types for the Gray-coded switch capture path.
// The downstream decoder imports GRAY_W from here so both stages agree on width.
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } gray_state_e;

  // True when a and b differ in exactly one bit position.
  function automatic logic single_bit_change(input logic [GRAY_W-1:0] a,
                                             input logic [GRAY_W-1:0] b);
    logic [GRAY_W-1:0] d;
    d = a ^ b;
    return (d != '0) && ((d & (d - GRAY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs.
// Bits are synchronized independently; the debouncer downstream absorbs skew between them.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gray_input_capture.sv
// Debounces a bouncing Gray-coded switch input and flags non-single-bit code steps.
// gray_valid is a one-cycle strobe with no backpressure: the consumer must take gray_code when it is high.
module gray_input_capture
  import gray_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GRAY_W-1:0] gray_raw,
  input  logic              err_clear,
  output logic [GRAY_W-1:0] gray_code,
  output logic              gray_valid,
  output logic              gray_error,
  output gray_state_e       state_dbg
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [GRAY_W-1:0] sync;
  gray_state_e       state, state_n;
  logic [GRAY_W-1:0] candidate, candidate_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [GRAY_W-1:0] code_n;
  logic              valid_n, error_n;

  sync_2ff #(.W(GRAY_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_raw),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      candidate  <= '0;
      cnt        <= '0;
      gray_code  <= '0;
      gray_valid <= 1'b0;
      gray_error <= 1'b0;
    end else begin
      state      <= state_n;
      candidate  <= candidate_n;
      cnt        <= cnt_n;
      gray_code  <= code_n;
      gray_valid <= valid_n;
      gray_error <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    candidate_n = candidate;
    cnt_n       = cnt;
    code_n      = gray_code;
    valid_n     = 1'b0;
    error_n     = err_clear ? 1'b0 : gray_error;

    unique case (state)
      IDLE: begin
        if (sync != gray_code) begin
          candidate_n = sync;
          cnt_n       = '0;
          state_n     = COUNT;
        end
      end
      COUNT: begin
        if (sync == candidate) begin
          if (cnt == CNT_LAST) begin
            state_n = COMMIT;
            code_n  = candidate;
            valid_n = 1'b1;
            // Setting the error wins over a same-cycle clear request.
            if (!single_bit_change(candidate, gray_code)) error_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (sync == gray_code) begin
          state_n = IDLE;
        end else begin
          candidate_n = sync;
          cnt_n       = '0;
        end
      end
      COMMIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_gray_input_capture.sv
// Self-checking bench for gray_input_capture with a 4-cycle debounce interval.
module tb_gray_input_capture;
  import gray_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic              clk;
  logic              rst_n;
  logic [GRAY_W-1:0] gray_raw;
  logic              err_clear;
  logic [GRAY_W-1:0] gray_code;
  logic              gray_valid;
  logic              gray_error;
  gray_state_e       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [GRAY_W:0]   exp_q[$];
  logic [GRAY_W-1:0] model_code;
  logic              model_err;

  gray_input_capture #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_raw   (gray_raw),
    .err_clear  (err_clear),
    .gray_code  (gray_code),
    .gray_valid (gray_valid),
    .gray_error (gray_error),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every gray_valid strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [GRAY_W:0] e;
    if (rst_n && gray_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(gray_code), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_code", 32'(gray_code), 32'(e[GRAY_W-1:0]));
        check("sb_err", 32'(gray_error), 32'(e[GRAY_W]));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Change gray_raw once and hold it; commit expected exactly LAT edges later.
  task automatic drive_change(input logic [GRAY_W-1:0] val, input bit clr_at_commit);
    logic exp_e;
    exp_e = ($countones(val ^ model_code) != 1) ? 1'b1 : (clr_at_commit ? 1'b0 : model_err);
    exp_q.push_back({exp_e, val});
    gray_raw = val;
    for (int i = 1; i <= LAT; i++) begin
      if (i == LAT && clr_at_commit) err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      if (i == LAT) check("valid_at_latency", 32'(gray_valid), 32'd1);
      else          check("valid_early", 32'(gray_valid), 32'd0);
    end
    check("commit_code", 32'(gray_code), 32'(val));
    check("commit_err", 32'(gray_error), 32'(exp_e));
    tick(1);
    check("valid_one_cycle", 32'(gray_valid), 32'd0);
    check("idle_after_commit", 32'(state_dbg), 32'(IDLE));
    model_code = val;
    model_err  = exp_e;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_code"}, 32'(gray_code), 32'd0);
    check({tag, "_valid"}, 32'(gray_valid), 32'd0);
    check({tag, "_err"}, 32'(gray_error), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    logic [GRAY_W-1:0] mask, val;
    int k;

    rst_n      = 1'b0;
    gray_raw   = '0;
    err_clear  = 1'b0;
    model_code = '0;
    model_err  = 1'b0;
    tick(3);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Quiet input after reset: nothing accepted.
    tick(12);
    check("quiet_code", 32'(gray_code), 32'd0);
    check("quiet_err", 32'(gray_error), 32'd0);

    // Single clean step.
    drive_change(4'b0001, 1'b0);
    tick(3);

    // Short excursion that bounces back to the held code.
    gray_raw = 4'b0011;
    tick(2);
    gray_raw = 4'b0001;
    tick(1);
    check("bounce_in_count", 32'(state_dbg), 32'(COUNT));
    tick(2);
    check("bounce_back_idle", 32'(state_dbg), 32'(IDLE));
    tick(8);
    check("bounce_code_kept", 32'(gray_code), 32'(4'b0001));

    // Toggle every 2 cycles for 20 cycles, then settle on 0011.
    for (int s = 0; s < 10; s++) begin
      gray_raw = (s % 2 == 0) ? 4'b0011 : 4'b0001;
      tick(2);
    end
    check("toggle_code_kept", 32'(gray_code), 32'(4'b0001));
    drive_change(4'b0011, 1'b0);
    tick(2);

    // Two-bit jump sets the sticky error; clear it; then clear loses to a new set.
    drive_change(4'b0000, 1'b0);
    tick(2);
    check("err_sticky", 32'(gray_error), 32'd1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("err_cleared", 32'(gray_error), 32'd0);
    model_err = 1'b0;
    tick(2);
    drive_change(4'b0011, 1'b1);
    tick(2);

    // Reset aborts a count in progress; full interval needed afterwards.
    rst_n    = 1'b0;
    gray_raw = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    model_code = '0;
    model_err  = 1'b0;
    tick(5);
    gray_raw = 4'b0001;
    tick(5);
    check("mid_count_state", 32'(state_dbg), 32'(COUNT));
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick(2);
    exp_q.push_back({1'b0, 4'b0001});
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick(1);
      if (i == LAT) check("post_reset_latency", 32'(gray_valid), 32'd1);
      else          check("post_reset_early", 32'(gray_valid), 32'd0);
    end
    model_code = 4'b0001;
    tick(2);

    // Random steps, mostly single-bit with occasional two-bit jumps.
    for (int r = 0; r < 8; r++) begin
      k    = $urandom_range(0, GRAY_W - 1);
      mask = 4'(1 << k);
      if ($urandom_range(0, 3) == 0) mask = mask | 4'(1 << ((k + 1) % GRAY_W));
      val = model_code ^ mask;
      drive_change(val, 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 3));
    end

    tick(4);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
